// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default frame geometry.
// The parity stage is only reachable when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

    localparam int DEF_DBIT    = 8;
    localparam int DEF_SB_TICK = 16;
    localparam int DEF_OS      = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; both flops reset to RST_VAL.
module uart_sync2 #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '1
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver feeding the RX FIFO write port (o_dout -> i_w_data, o_rx_done_tick -> i_wr).
// Define UART_RX_PARITY_EN to add a parity bit after the data bits (PAR_ODD selects odd sense).
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DBIT    = DEF_DBIT,
    parameter int SB_TICK = DEF_SB_TICK,
    parameter int OS      = DEF_OS
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PAR_ODD = 1'b0
`endif
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_rx,
    input  logic            i_s_tick,
    output logic [DBIT-1:0] o_dout,
    output logic            o_rx_done_tick,
    output logic            o_frame_err,
    output logic            o_parity_err
);

    localparam int SW = $clog2(OS) + 1;
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_MID  = SW'(OS / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OS - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] S_ONE  = SW'(1);
    localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
    localparam logic [NW-1:0] N_ONE  = NW'(1);

    logic rx_s;

    uart_sync2 #(.W(1), .RST_VAL(1'b1)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .d       (i_rx),
        .q       (rx_s)
    );

    uart_state_e     state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [DBIT-1:0] dout_reg, dout_next;
    logic            done_reg, done_next;
    logic            ferr_reg, ferr_next;
`ifdef UART_RX_PARITY_EN
    logic            par_reg, par_next;
    logic            perr_reg, perr_next;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            done_reg  <= 1'b0;
            ferr_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            done_reg  <= done_next;
            ferr_reg  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            par_reg   <= par_next;
            perr_reg  <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout_reg;
        done_next  = 1'b0;
        ferr_next  = ferr_reg;
`ifdef UART_RX_PARITY_EN
        par_next   = par_reg;
        perr_next  = perr_reg;
`endif
        case (state_reg)
            // Leaving IDLE is edge-driven, not tick-driven, so back-to-back frames need no dead time.
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (s_reg == S_MID) begin
                        if (rx_s) begin
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end
                    end else begin
                        s_next = s_reg + S_ONE;
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (s_reg == S_LAST) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + N_ONE;
                        end
                    end else begin
                        s_next = s_reg + S_ONE;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_s_tick) begin
                    if (s_reg == S_LAST) begin
                        par_next   = rx_s;
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + S_ONE;
                    end
                end
            end
`endif
            // A bad stop bit still delivers the word; the error flag travels with it.
            STOP: begin
                if (i_s_tick) begin
                    if (s_reg == S_STOP) begin
                        dout_next  = b_reg;
                        ferr_next  = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_next  = ^b_reg ^ par_reg ^ PAR_ODD;
`endif
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        s_next = s_reg + S_ONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_dout         = dout_reg;
    assign o_rx_done_tick = done_reg;
    assign o_frame_err    = ferr_reg;
`ifdef UART_RX_PARITY_EN
    assign o_parity_err   = perr_reg;
`else
    assign o_parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx: a frame-level model queues expected words and a compare process
// checks every non-reset cycle. Parity frames are exercised when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int BIT_CLK = 64;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM = 608 + BIT_CLK;
`else
    localparam int LAT_NOM = 608;
`endif
    localparam int LAT_MIN = LAT_NOM - 3;
    localparam int LAT_MAX = LAT_NOM + 7;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_rx;
    logic       i_s_tick;
    logic [7:0] o_dout;
    logic       o_rx_done_tick;
    logic       o_frame_err;
    logic       o_parity_err;

    uart_rx dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_rx           (i_rx),
        .i_s_tick       (i_s_tick),
        .o_dout         (o_dout),
        .o_rx_done_tick (o_rx_done_tick),
        .o_frame_err    (o_frame_err),
        .o_parity_err   (o_parity_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] d;
        logic       ferr;
        logic       perr;
        int         t0;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_done   = 0;
    int         cyc      = 0;
    logic [7:0] m_dout   = '0;
    logic       m_ferr   = 1'b0;
    logic       m_perr   = 1'b0;
    logic       prev_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge i_clk) cyc <= cyc + 1;

    // Baud tick: one strobe every 4 clocks.
    initial begin
        int tcnt;
        tcnt     = 0;
        i_s_tick = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            tcnt     = (tcnt + 1) % 4;
            i_s_tick = (tcnt == 0);
        end
    end

    always @(negedge i_clk) begin
        if (i_reset) begin
            m_dout = '0;
            m_ferr = 1'b0;
            m_perr = 1'b0;
        end else begin
            if (o_rx_done_tick) begin
                n_done++;
                chk("done_one_clock", {31'd0, prev_done}, 32'd0);
                chk("done_expected", {31'd0, exp_q.size() > 0}, 32'd1);
                if (exp_q.size() > 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_latency_in_window",
                        {31'd0, (cyc - e.t0 >= LAT_MIN) && (cyc - e.t0 <= LAT_MAX)}, 32'd1);
                    m_dout = e.d;
                    m_ferr = e.ferr;
                    m_perr = e.perr;
                end
            end else if (exp_q.size() > 0) begin
                chk("done_deadline", {31'd0, (cyc - exp_q[0].t0) <= LAT_MAX}, 32'd1);
                if (cyc - exp_q[0].t0 > LAT_MAX) void'(exp_q.pop_front());
            end
            chk("dout", {24'd0, o_dout}, {24'd0, m_dout});
            chk("frame_err", {31'd0, o_frame_err}, {31'd0, m_ferr});
            chk("parity_err", {31'd0, o_parity_err}, {31'd0, m_perr});
        end
        prev_done = o_rx_done_tick;
    end

    task automatic clk(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Drives one frame LSB first; a bad stop bit is low through its centre then rises before the next bit slot.
    task automatic send_frame(input logic [7:0] d, input bit good_stop, input bit par, input int gap);
        exp_t e;
        int   g;
        e.d    = d;
        e.ferr = ~good_stop;
`ifdef UART_RX_PARITY_EN
        e.perr = (par != ^d);
`else
        e.perr = 1'b0;
`endif
        e.t0   = cyc;
        exp_q.push_back(e);
        i_rx = 1'b0;
        clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            clk(BIT_CLK);
        end
`ifdef UART_RX_PARITY_EN
        i_rx = par;
        clk(BIT_CLK);
`endif
        if (good_stop) begin
            i_rx = 1'b1;
            clk(BIT_CLK);
        end else begin
            i_rx = 1'b0;
            clk(40);
            i_rx = 1'b1;
            clk(BIT_CLK - 40);
        end
        i_rx = 1'b1;
        g = (!good_stop && gap < BIT_CLK) ? BIT_CLK : gap;
        if (g > 0) clk(g);
    endtask

    initial begin
        int d0;
        i_reset = 1'b1;
        i_rx    = 1'b1;
        clk(5);
        i_reset = 1'b0;
        clk(2);
        chk("reset_dout", {24'd0, o_dout}, 32'h0);
        chk("reset_done", {31'd0, o_rx_done_tick}, 32'h0);
        chk("reset_ferr", {31'd0, o_frame_err}, 32'h0);
        chk("reset_perr", {31'd0, o_parity_err}, 32'h0);
        clk(50);

        d0 = n_done;
        send_frame(8'hA5, 1'b1, 1'b0, 100);
        chk("a5_count", n_done - d0, 32'd1);
        chk("a5_dout", {24'd0, o_dout}, 32'hA5);
        chk("a5_ferr", {31'd0, o_frame_err}, 32'h0);

        d0 = n_done;
        i_rx = 1'b0;
        clk(20);
        i_rx = 1'b1;
        clk(200);
        chk("glitch_count", n_done - d0, 32'd0);
        chk("glitch_dout", {24'd0, o_dout}, 32'hA5);

        send_frame(8'h3C, 1'b0, 1'b0, 100);
        chk("3c_dout", {24'd0, o_dout}, 32'h3C);
        chk("3c_ferr", {31'd0, o_frame_err}, 32'h1);
        send_frame(8'h01, 1'b1, 1'b1, 100);
        chk("01_dout", {24'd0, o_dout}, 32'h01);
        chk("01_ferr", {31'd0, o_frame_err}, 32'h0);

        d0 = n_done;
        send_frame(8'h00, 1'b1, 1'b0, 0);
        send_frame(8'hFF, 1'b1, 1'b0, 0);
        send_frame(8'h55, 1'b1, 1'b0, 100);
        chk("b2b_count", n_done - d0, 32'd3);
        chk("b2b_last", {24'd0, o_dout}, 32'h55);

        // Break: line low through the first stop-bit centre, then released before a second start completes.
        begin
            exp_t e;
            e.d = 8'h00; e.ferr = 1'b1; e.perr = 1'b0; e.t0 = cyc;
`ifdef UART_RX_PARITY_EN
            e.perr = 1'b0;
`endif
            exp_q.push_back(e);
            i_rx = 1'b0;
            clk(LAT_NOM + 12);
            i_rx = 1'b1;
            clk(200);
            chk("break_dout", {24'd0, o_dout}, 32'h00);
            chk("break_ferr", {31'd0, o_frame_err}, 32'h1);
        end

        // Reset during data bit 4 of 0x77.
        d0 = n_done;
        i_rx = 1'b0;
        clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            i_rx = (8'h77 >> i) & 1;
            clk(BIT_CLK);
        end
        i_rx = 1'b1;
        clk(BIT_CLK / 2);
        i_reset = 1'b1;
        clk(5);
        i_reset = 1'b0;
        clk(200);
        chk("rst_count", n_done - d0, 32'd0);
        chk("rst_dout", {24'd0, o_dout}, 32'h0);
        chk("rst_ferr", {31'd0, o_frame_err}, 32'h0);
        send_frame(8'h12, 1'b1, 1'b0, 100);
        chk("12_dout", {24'd0, o_dout}, 32'h12);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 100);
        chk("par_good", {31'd0, o_parity_err}, 32'h0);
        send_frame(8'h07, 1'b1, 1'b0, 100);
        chk("par_bad", {31'd0, o_parity_err}, 32'h1);
`endif

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                i_rx = 1'b0;
                clk($urandom_range(1, 20));
                i_rx = 1'b1;
                clk($urandom_range(60, 120));
            end
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 3) != 0,
                       1'($urandom_range(0, 1)), $urandom_range(0, 100));
        end

        clk(LAT_MAX + 100);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
